fwd_ctrl: RTL and testbench
===========================

Name: fwd_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipeline.
- Shadows the destination-register info of the EX, MEM and WB stages in its own pipeline registers.
- Drives the 2-bit select lines of the two EX-stage operand 3-to-1 muxes: 00 = register file, 01 = WB result, 10 = MEM result.
- Raises a stall request on load-use hazards.

Parameters:
- RW, 5, register-address width.
- NREG_ZERO, 0, hard-wired zero register index; never forwarded, never stalls.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global pipeline freeze (cache miss); no internal register updates.
- flush  in  1  branch/jump flush; the instruction entering EX becomes a bubble.
- id_rs  in  RW  source register A of the instruction in ID.
- id_rt  in  RW  source register B of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  RW  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes a register.
- id_memread  in  1  ID instruction is a load.
- fwd_a  out  2  EX operand A mux select.
- fwd_b  out  2  EX operand B mux select.
- stall  out  1  load-use stall request to PC/IF-ID registers.

Behaviour:
- Internal stage registers:
  - EX: rs, rt, use_rs, use_rt, rd, regwrite, memread.
  - MEM: rd, regwrite, memread.
  - WB: rd, regwrite.
- Reset (rst_n low, async): all internal regwrite/memread/use bits = 0, all addresses = 0. Outputs at reset: fwd_a = 00, fwd_b = 00, stall = 0.
- Each rising clk edge, when hold = 0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID inputs, unless stall = 1 or flush = 1. In that case EX <= bubble (regwrite = 0, memread = 0, use_rs = 0, use_rt = 0).
- hold = 1: all stage registers keep their value. flush and stall are not acted on that cycle; the upstream controller keeps flush asserted until hold drops.
- fwd_a (combinational from stage registers), evaluated for EX.rs / EX.use_rs, in priority order:
  1. 10 if MEM.regwrite and MEM.rd == EX.rs and MEM.rd != NREG_ZERO and MEM.memread == 0.
  2. else 01 if WB.regwrite and WB.rd == EX.rs and WB.rd != NREG_ZERO.
  3. else 00.
  - All cases require EX.use_rs = 1; otherwise fwd_a = 00.
- fwd_b: same rules using EX.rt / EX.use_rt.
- A load in MEM is never forwarded from MEM (its data is not available yet). This case cannot occur after a correct stall; if it does, fall through to the WB check.
- Value 11 is never driven; the mux maps 11 to 0.
- stall (combinational) = EX.memread & EX.regwrite & (EX.rd != NREG_ZERO) & ((id_use_rs & id_rs == EX.rd) | (id_use_rt & id_rt == EX.rd)).
  - stall is exactly 1 cycle per load-use pair: the bubble enters EX, so the next cycle EX.memread = 0.
  - stall is forced to 0 when flush = 1, since the ID instruction is discarded.
- flush and stall together: flush wins; bubble inserted, stall = 0.
- Latency: selects are valid in the same cycle an instruction occupies EX; no added pipeline delay.

Optional Feature:
- Macro: FWD_STATS_EN.
- Defined:
  - Adds output ports stall_cnt [31:0] and fwd_cnt [31:0], both reset to 0 asynchronously.
  - stall_cnt increments on each clk edge with stall = 1 and hold = 0.
  - fwd_cnt increments by 1 or 2 (one per nonzero select among fwd_a and fwd_b) under hold = 0.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: rst_n = 0 mid-run with EX holding a load → fwd_a = fwd_b = 00 and stall = 0 immediately, before any clk edge.
- EX/MEM forward:
  - Setup: add r3 in ID (regwrite = 1), then sub using rs = 3 in the next cycle.
  - Required: after 2 edges fwd_a = 10, fwd_b = 00.
  - Same instruction with rs = 0 and rd = 0 → fwd_a = 00.
- WB forward and priority:
  - Setup: r5 written by two consecutive instructions, followed by a reader of rs = rt = 5.
  - Required: fwd_a = fwd_b = 10 (newest wins).
  - With one unrelated instruction between writer and reader: fwd = 01.
- Load-use:
  - Setup: lw r7 in EX, ID instruction reading rt = 7.
  - Required: stall = 1 for exactly 1 cycle; next cycle EX is a bubble; following cycle reader in EX with fwd_b = 01.
- Hold and flush:
  - hold = 1 for 3 cycles → fwd and stall outputs unchanged.
  - flush = 1 together with a load-use condition → stall = 0 and EX becomes a bubble (fwd = 00 next cycle).
- FWD_STATS_EN: 4 load-use pairs and 6 single-operand forwards with no hold → stall_cnt = 4, fwd_cnt = 6.

Source files
------------

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and load-use hazard controller for the 5-stage pipeline.
//
// Shadows the destination-register info of the EX, MEM and WB stages and drives
// the EX operand mux selects (00 = register file, 01 = WB result, 10 = MEM result).
// It also raises a one-cycle stall request when a load in EX feeds the instruction in ID.
//
// Ports:
//   clk, rst_n           pipeline clock (rising edge), async active-low reset
//   hold                 global freeze; no stage register updates
//   flush                instruction entering EX becomes a bubble
//   id_*                 source/destination info of the instruction in ID
//   fwd_a, fwd_b         EX operand A/B mux selects
//   stall                load-use stall request to PC / IF-ID
//   stall_cnt, fwd_cnt   event counters, present only with FWD_STATS_EN defined
//
// Optional feature macro: FWD_STATS_EN (adds stall_cnt / fwd_cnt outputs).

module fwd_ctrl #(
  parameter int unsigned RW        = 5,
  parameter int unsigned NREG_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fwd_cnt
`endif
);

  localparam logic [RW-1:0] ZeroReg = RW'(NREG_ZERO);
  localparam logic [1:0]    SelRf   = 2'b00;
  localparam logic [1:0]    SelWb   = 2'b01;
  localparam logic [1:0]    SelMem  = 2'b10;

  // EX stage shadow
  logic [RW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic          ex_use_rs_q, ex_use_rt_q, ex_regwrite_q, ex_memread_q;
  // MEM stage shadow
  logic [RW-1:0] mem_rd_q;
  logic          mem_regwrite_q, mem_memread_q;
  // WB stage shadow
  logic [RW-1:0] wb_rd_q;
  logic          wb_regwrite_q;

  logic          bubble;

  // A load sitting in MEM has no data yet, so it is skipped and WB is checked instead.
  function automatic logic [1:0] sel_for(input logic          use_src,
                                         input logic [RW-1:0] src,
                                         input logic          mem_rw,
                                         input logic          mem_ld,
                                         input logic [RW-1:0] mem_rd,
                                         input logic          wb_rw,
                                         input logic [RW-1:0] wb_rd);
    logic [1:0] sel;
    sel = SelRf;
    if (use_src) begin
      if (mem_rw && !mem_ld && (mem_rd != ZeroReg) && (mem_rd == src)) begin
        sel = SelMem;
      end else if (wb_rw && (wb_rd != ZeroReg) && (wb_rd == src)) begin
        sel = SelWb;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = sel_for(ex_use_rs_q, ex_rs_q, mem_regwrite_q, mem_memread_q, mem_rd_q,
                    wb_regwrite_q, wb_rd_q);
    fwd_b = sel_for(ex_use_rt_q, ex_rt_q, mem_regwrite_q, mem_memread_q, mem_rd_q,
                    wb_regwrite_q, wb_rd_q);
  end

  always_comb begin
    logic load_in_ex;
    logic id_hit;
    load_in_ex = ex_memread_q & ex_regwrite_q & (ex_rd_q != ZeroReg);
    id_hit     = (id_use_rs & (id_rs == ex_rd_q)) | (id_use_rt & (id_rt == ex_rd_q));
    // A flushed ID instruction is discarded, so it can never need a stall.
    stall      = load_in_ex & id_hit & ~flush;
  end

  assign bubble = stall | flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_use_rs_q    <= 1'b0;
      ex_use_rt_q    <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else if (!hold) begin
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memread_q  <= ex_memread_q;
      if (bubble) begin
        ex_rs_q       <= '0;
        ex_rt_q       <= '0;
        ex_rd_q       <= '0;
        ex_use_rs_q   <= 1'b0;
        ex_use_rt_q   <= 1'b0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
      end else begin
        ex_rs_q       <= id_rs;
        ex_rt_q       <= id_rt;
        ex_rd_q       <= id_rd;
        ex_use_rs_q   <= id_use_rs;
        ex_use_rt_q   <= id_use_rt;
        ex_regwrite_q <= id_regwrite;
        ex_memread_q  <= id_memread;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [1:0] fwd_inc;

  always_comb begin
    fwd_inc = {1'b0, (fwd_a != SelRf)} + {1'b0, (fwd_b != SelRf)};
  end

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!hold) begin
      stall_cnt <= stall_cnt + {31'd0, stall};
      fwd_cnt   <= fwd_cnt + {30'd0, fwd_inc};
    end
  end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed hazard scenarios plus randomized
// instruction streams, compared against an instruction-level pipeline model.

module tb_fwd_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  fwd_ctrl #(.RW(5), .NREG_ZERO(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .flush       (flush),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the instructions currently occupying EX, MEM and WB.
  instr_t      m_ex, m_mem, m_wb;
  logic        m_last_stall;
  logic [31:0] m_stall_cnt, m_fwd_cnt;
  logic [1:0]  obs_a, obs_b;
  logic        obs_st;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                input int rd, input bit rw, input bit ld);
    instr_t i;
    i.rs = rs[4:0]; i.rt = rt[4:0]; i.use_rs = urs; i.use_rt = urt;
    i.rd = rd[4:0]; i.regwrite = rw; i.memread = ld;
    return i;
  endfunction

  // Newest usable producer wins; a load still in MEM cannot supply data.
  function automatic logic [1:0] exp_sel(input logic use_src, input logic [4:0] src);
    if (!use_src || src == 5'd0) return 2'd0;
    if (m_mem.regwrite && !m_mem.memread && m_mem.rd == src) return 2'd2;
    if (m_wb.regwrite && m_wb.rd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic exp_stall(input instr_t i, input logic f);
    logic needs;
    needs = (i.use_rs && i.rs == m_ex.rd) || (i.use_rt && i.rt == m_ex.rd);
    return !f && m_ex.memread && m_ex.regwrite && m_ex.rd != 5'd0 && needs;
  endfunction

  task automatic model_clear();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_last_stall = 1'b0; m_stall_cnt = '0; m_fwd_cnt = '0;
  endtask

  task automatic drive(input instr_t i, input logic h, input logic f);
    hold = h; flush = f;
    id_rs = i.rs; id_rt = i.rt; id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_rd = i.rd; id_regwrite = i.regwrite; id_memread = i.memread;
  endtask

  // One clock cycle: present ID inputs, compare outputs mid-cycle, then advance model.
  task automatic step(input instr_t i, input logic h, input logic f);
    logic [1:0] ea, eb;
    logic       es;
    @(negedge clk);
    drive(i, h, f);
    #1;
    ea = exp_sel(m_ex.use_rs, m_ex.rs);
    eb = exp_sel(m_ex.use_rt, m_ex.rt);
    es = exp_stall(i, f);
    check_eq("fwd_a", fwd_a, ea);
    check_eq("fwd_b", fwd_b, eb);
    check_eq("stall", stall, es);
    obs_a = fwd_a; obs_b = fwd_b; obs_st = stall;
    m_last_stall = es;
    @(posedge clk);
    if (!h) begin
      m_stall_cnt = m_stall_cnt + {31'd0, es};
      m_fwd_cnt   = m_fwd_cnt + ((ea != 0) ? 1 : 0) + ((eb != 0) ? 1 : 0);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (es || f) ? '0 : i;
    end
  endtask

  // Issue an instruction, re-presenting it while the pipeline stalls it in ID.
  task automatic issue(input instr_t i);
    for (int k = 0; k < 4; k++) begin
      step(i, 1'b0, 1'b0);
      if (!m_last_stall) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0);
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  instr_t nop, rd_r7, ri;

  initial begin
    nop   = '0;
    rd_r7 = mk(1, 7, 0, 1, 9, 1, 0);
    rst_n = 1'b0;
    drive(nop, 1'b0, 1'b0);
    model_clear();
    #3;
    check_eq("rst_fwd_a", fwd_a, 0);
    check_eq("rst_fwd_b", fwd_b, 0);
    check_eq("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // EX/MEM forward
    issue(mk(1, 2, 1, 1, 3, 1, 0));
    issue(mk(3, 4, 1, 0, 8, 1, 0));
    step(nop, 0, 0);
    check_eq("exmem_a", obs_a, 2);
    check_eq("exmem_b", obs_b, 0);
    // zero register never forwarded
    issue(mk(1, 2, 1, 1, 0, 1, 0));
    issue(mk(0, 4, 1, 0, 8, 1, 0));
    step(nop, 0, 0);
    check_eq("zero_a", obs_a, 0);

    // Two writers of r5: newest (MEM) wins
    issue(mk(1, 2, 0, 0, 5, 1, 0));
    issue(mk(1, 2, 0, 0, 5, 1, 0));
    issue(mk(5, 5, 1, 1, 6, 1, 0));
    step(nop, 0, 0);
    check_eq("prio_a", obs_a, 2);
    check_eq("prio_b", obs_b, 2);
    // One unrelated instruction between: WB forward
    issue(mk(1, 2, 0, 0, 5, 1, 0));
    issue(mk(1, 2, 0, 0, 11, 1, 0));
    issue(mk(5, 5, 1, 1, 6, 1, 0));
    step(nop, 0, 0);
    check_eq("wb_a", obs_a, 1);
    check_eq("wb_b", obs_b, 1);

    // Load-use: lw r7, then reader of rt = 7
    issue(mk(1, 2, 1, 0, 7, 1, 1));
    step(rd_r7, 0, 0);
    check_eq("lu_stall1", obs_st, 1);
    step(rd_r7, 0, 0);
    check_eq("lu_stall2", obs_st, 0);
    check_eq("lu_bubble_b", obs_b, 0);
    step(nop, 0, 0);
    check_eq("lu_fwd_b", obs_b, 1);

    // Hold with a forward in EX and a load-use pending
    issue(mk(1, 2, 0, 0, 5, 1, 0));
    issue(mk(5, 5, 1, 1, 6, 1, 0));
    for (int k = 0; k < 3; k++) begin
      step(nop, 1, 0);
      check_eq("hold_fwd_a", obs_a, 2);
    end
    step(nop, 0, 0);
    issue(mk(1, 2, 1, 0, 7, 1, 1));
    for (int k = 0; k < 3; k++) begin
      step(rd_r7, 1, 0);
      check_eq("hold_stall", obs_st, 1);
    end
    issue(rd_r7);
    step(nop, 0, 0);

    // Flush wins over load-use
    issue(mk(1, 2, 1, 0, 7, 1, 1));
    step(rd_r7, 0, 1);
    check_eq("flush_stall", obs_st, 0);
    step(nop, 0, 0);
    check_eq("flush_bub_a", obs_a, 0);
    check_eq("flush_bub_b", obs_b, 0);

    // Async reset mid-run with a load in EX
    issue(mk(1, 2, 1, 0, 7, 1, 1));
    @(negedge clk);
    drive(rd_r7, 0, 0);
    #1;
    check_eq("pre_rst_stall", stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", fwd_a, 0);
    check_eq("async_rst_b", fwd_b, 0);
    check_eq("async_rst_stall", stall, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized streams over a small register file to provoke hazards
    for (int n = 0; n < 600; n++) begin
      ri.rs       = 5'($urandom_range(0, 3));
      ri.rt       = 5'($urandom_range(0, 3));
      ri.rd       = 5'($urandom_range(0, 3));
      ri.use_rs   = 1'($urandom_range(0, 1));
      ri.use_rt   = 1'($urandom_range(0, 1));
      ri.regwrite = ($urandom_range(0, 4) != 0);
      ri.memread  = ri.regwrite && ($urandom_range(0, 2) == 0);
      step(ri, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

`ifdef FWD_STATS_EN
    @(negedge clk);
    #1;
    check_eq("rand_stall_cnt", stall_cnt, m_stall_cnt);
    check_eq("rand_fwd_cnt", fwd_cnt, m_fwd_cnt);
    do_reset();
    // 4 load-use pairs (each reader then takes one WB forward) + 2 MEM forwards
    for (int k = 1; k <= 4; k++) begin
      issue(mk(0, 0, 0, 0, k, 1, 1));
      issue(mk(0, k, 0, 1, 12, 0, 0));
      issue(nop);
    end
    for (int k = 0; k < 2; k++) begin
      issue(mk(0, 0, 0, 0, 6, 1, 0));
      issue(mk(6, 0, 1, 0, 13, 0, 0));
      issue(nop);
    end
    step(nop, 0, 0);
    @(negedge clk);
    #1;
    check_eq("stats_stall_cnt", stall_cnt, 4);
    check_eq("stats_fwd_cnt", fwd_cnt, 6);
    check_eq("stats_model_fwd", fwd_cnt, m_fwd_cnt);
`else
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
